joypad_pad_scanner: RTL
=======================

Name: joypad_pad_scanner

Overview:
- Autonomous poller for an NES/SNES-style serial pad (latch/clock/data) that feeds the joypad button register over its Avalon-slave write port.
- Periodically scans 8 buttons, debounces across consecutive scans, and issues a single-cycle register write only when the stable button set changes.
- Replaces HPS software polling of the joypad register; sits between board GPIO and the joypad slave.

Parameters:
CLK_DIV, 300, clk cycles per pad_clk half-period; legal range 4 or more.
POLL_PERIOD, 833333, clk cycles between scan starts (60 Hz at 50 MHz).
DEBOUNCE_SCANS, 2, consecutive identical scans required before a value is accepted; legal range 1 to 15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  polling enable; sampled in IDLE only
pad_data  in  1  serial button data from pad, active-low (0 = pressed), asynchronous
pad_latch  out  1  parallel-load strobe to pad, active-high
pad_clk  out  1  shift clock to pad, idles high
writedata_mst  out  8  button byte: [0]Right [1]Left [2]Up [3]Down [4]A [5]B [6]Select [7]Start, 1 = pressed
write_mst  out  1  write strobe to joypad slave
chipselect_mst  out  1  chipselect to joypad slave; identical to write_mst
busy  out  1  high from LATCH entry through DONE

Behaviour:
- Reset (sync, active-high, clk only): state IDLE, poll timer 0, pad_latch 0, pad_clk 1, write_mst 0, chipselect_mst 0, writedata_mst 0x00, busy 0, candidate 0x00, stable count 0, last_written 0x00. Applies mid-scan: next cycle outputs are at reset values, and the partial scan is discarded.
- pad_data passes through a 2-FF synchronizer before use.
- Poll timer: free-running down-counter. It reloads POLL_PERIOD-1 on the LATCH entry cycle and decrements otherwise, saturating at 0.
- IDLE: if timer == 0 and enable == 1, go to LATCH. Otherwise stay. An expired timer waits for enable without loss.
- LATCH: pad_latch = 1 for 2*CLK_DIV cycles, pad_clk = 1. Then go to SHIFT with bit index 0.
- SHIFT, per bit i = 0..7:
  - High phase: pad_clk = 1 for CLK_DIV cycles. The synchronized pad_data is sampled in the last cycle of this phase into shift[i], stored inverted.
  - Low phase: pad_clk = 0 for CLK_DIV cycles. The rising pad_clk edge at its end advances the pad to the next bit.
  - After the low phase of bit 7, go to DONE.
- Pad serial order: i = 0..7 is A, B, Select, Start, Up, Down, Left, Right. Mapping to writedata_mst: A->4, B->5, Select->6, Start->7, Up->2, Down->3, Left->1, Right->0.
- DONE (1 cycle), debounce:
  - If the mapped byte equals candidate, stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise candidate <= byte and stable count <= 1.
  - If the updated count is DEBOUNCE_SCANS and candidate differs from last_written, a write is pending and last_written is updated.
  - Then go to IDLE.
- Write: on the cycle after DONE, write_mst = chipselect_mst = 1 for exactly one cycle, with writedata_mst = new value. writedata_mst holds that value until the next write.
- Total scan length: 18*CLK_DIV + 1 cycles (LATCH + SHIFT + DONE). If the timer expires during a scan, the next scan starts on the first IDLE cycle.
- Enable deasserted mid-scan: the scan completes normally, including debounce and any write. No new scan starts while enable == 0.
- DEBOUNCE_SCANS = 1: every changed scan writes on its own DONE.

Test Plan:
- Reset values: hold reset 3 cycles -> pad_clk 1, pad_latch 0, write_mst 0, writedata_mst 0x00, busy 0.
- Scan timing (CLK_DIV=4, POLL_PERIOD=200, enable=1 from reset release): pad_latch high 8 cycles, then 8 pad_clk low pulses of 4 cycles each, busy high 73 cycles; second LATCH starts 200 cycles after the first.
- Debounce and mapping (DEBOUNCE_SCANS=2): pad model drives A and Up pressed (pad_data 0 at i=0 and i=4) on every scan -> no write after scan 1; after scan 2, one write_mst pulse with writedata_mst = 0x14. Scan 3 identical -> no write.
- Glitch rejection: scans return 0x14, 0x80, 0x14, 0x14 -> exactly one write, 0x14, after the 4th scan. Then release all buttons for 2 scans -> one write of 0x00.
- Enable drop: deassert enable during SHIFT bit 3 -> the scan finishes, busy falls, pad_latch stays 0 for 1000 cycles. Reassert -> LATCH starts the next cycle.
- Reset mid-scan: assert reset during SHIFT bit 5 after a prior write of 0x14 -> next cycle pad_clk 1, busy 0, writedata_mst 0x00. After release, 2 scans of 0x14 -> write of 0x14 reissued.

Source files
------------

// File: rtl/joypad_pad_scanner.sv
// Autonomous NES/SNES serial pad poller: latches, shifts 8 buttons, debounces
// across scans and issues a one-cycle register write when the stable set changes.
module joypad_pad_scanner #(
  parameter int CLK_DIV        = 300,
  parameter int POLL_PERIOD    = 833333,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] writedata_mst,
  output logic       write_mst,
  output logic       chipselect_mst,
  output logic       busy
);

  // state      | meaning
  // S_IDLE     | waiting for poll timer expiry with enable high
  // S_LATCH    | pad_latch high, pad loads its buttons
  // S_SHIFT_HI | pad_clk high, bit sampled on the last cycle
  // S_SHIFT_LO | pad_clk low, rising edge at its end advances the pad
  // S_DONE     | debounce update, decides whether a write follows
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SHIFT_HI, S_SHIFT_LO, S_DONE} state_t;

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  sync_q, sync_d;
  logic [7:0]  cand_q, cand_d;
  logic [3:0]  stable_q, stable_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        latch_q, latch_d;
  logic        pclk_q, pclk_d;
  logic        busy_q, busy_d;
  logic [7:0]  mapped;

  // Serial order A,B,Select,Start,Up,Down,Left,Right into register bit layout
  assign mapped = {shift_q[3], shift_q[2], shift_q[1], shift_q[0],
                   shift_q[5], shift_q[4], shift_q[6], shift_q[7]};

  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q != '0) ? timer_q - 1'b1 : '0;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sync_d   = {sync_q[0], pad_data};
    cand_d   = cand_q;
    stable_d = stable_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (timer_q == '0 && enable) begin
          state_d = S_LATCH;
          cnt_d   = CW'(2 * CLK_DIV - 1);
          timer_d = TW'(POLL_PERIOD - 1);
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT_HI;
          cnt_d   = CW'(CLK_DIV - 1);
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == '0) begin
          shift_d[bit_q] = ~sync_q[1];
          state_d        = S_SHIFT_LO;
          cnt_d          = CW'(CLK_DIV - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == '0) begin
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT_HI;
            bit_d   = bit_q + 3'd1;
            cnt_d   = CW'(CLK_DIV - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (mapped == cand_q) begin
          if (stable_q != 4'(DEBOUNCE_SCANS)) stable_d = stable_q + 4'd1;
        end else begin
          cand_d   = mapped;
          stable_d = 4'd1;
        end
        if (stable_d == 4'(DEBOUNCE_SCANS) && cand_d != last_q) begin
          last_d  = cand_d;
          wdata_d = cand_d;
          write_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q
    latch_d = (state_d == S_LATCH);
    pclk_d  = (state_d != S_SHIFT_LO);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      sync_q   <= 2'b11;
      cand_q   <= 8'h00;
      stable_q <= 4'd0;
      last_q   <= 8'h00;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      latch_q  <= 1'b0;
      pclk_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sync_q   <= sync_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      last_q   <= last_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      latch_q  <= latch_d;
      pclk_q   <= pclk_d;
      busy_q   <= busy_d;
    end
  end

  assign pad_latch      = latch_q;
  assign pad_clk        = pclk_q;
  assign writedata_mst  = wdata_q;
  assign write_mst      = write_q;
  assign chipselect_mst = write_q;
  assign busy           = busy_q;

endmodule
